uart_tx_ctrl: RTL and testbench

Parametrised UART transmitter that serialises one character per request over `uart_tx`. It accepts a frame through the `req`/`req_ack` handshake. Each frame carries its own stop-bit count, parity mode and bit period, and the block adds a programmable character width, odd/even parity, 1.5 stop bits and `busy`/`done` status. It sits between a bus-side register block or test driver and the serial pin.

---
 rtl/uart_tx_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmitter with per-frame stop/parity/baud shadow registers
//
// Purpose:
//   Serialises one DATA_W-bit character per accepted request onto uart_tx:
//   start bit, data bits LSB first, optional parity bit, then 1, 1.5 or 2
//   stop bits. The whole frame configuration is captured at acceptance, so
//   inputs may change freely while a frame is in flight.
//
// Parameters:
//   DATA_W     character width in bits (5..9)
//   BAUD_W     width of the baudrate field
//
// Ports:
//   clk        in   clock
//   resetn     in   asynchronous active-low reset
//   tx_data    in   character to send, LSB first
//   stop       in   stop code: 00/11 = 1, 01 = 2, 10 = 1.5 stop bits
//   parity_en  in   1 appends a parity bit
//   parity_odd in   0 = even parity, 1 = odd parity
//   baudrate   in   bit period minus one, in clk cycles
//   req        in   level-sensitive transmit request
//   req_ack    out  one-cycle pulse when a request is accepted
//   busy       out  high from acceptance to the end of the last stop bit
//   done       out  one-cycle pulse after the final stop bit
//   uart_tx    out  serial line, idles high

module uart_tx_ctrl #(
  parameter int DATA_W = 8,
  parameter int BAUD_W = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [1:0]        stop,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic [BAUD_W-1:0] baudrate,
  input  logic              req,
  output logic              req_ack,
  output logic              busy,
  output logic              done,
  output logic              uart_tx
);

  localparam int IDX_W = $clog2(DATA_W);
  // One extra bit so that a two-period stop time cannot overflow.
  localparam int CNT_W = BAUD_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // State and counters
  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [IDX_W-1:0]  r_bit_idx;
  logic [IDX_W-1:0]  w_bit_idx_nxt;

  // Shadow copy of the frame configuration
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_nxt;
  logic [BAUD_W-1:0] r_baud;
  logic [BAUD_W-1:0] w_baud_nxt;
  logic [1:0]        r_stop;
  logic [1:0]        w_stop_nxt;
  logic              r_par_en;
  logic              w_par_en_nxt;
  logic              r_par_bit;
  logic              w_par_bit_nxt;

  // Registered outputs
  logic              r_tx;
  logic              w_tx_nxt;
  logic              r_ack;
  logic              w_ack_nxt;
  logic              r_busy;
  logic              w_busy_nxt;
  logic              r_done;
  logic              w_done_nxt;

  // Bit timing helpers
  logic [CNT_W-1:0]  w_bit_load;
  logic [CNT_W-1:0]  w_period;
  logic [CNT_W-1:0]  w_stop_load;
  logic              w_bit_end;

  // The counter is loaded with (duration - 1) and counts down to zero, so a
  // bit ends on the cycle where r_cnt is zero.
  assign w_bit_load = {1'b0, r_baud};
  assign w_period   = w_bit_load + CNT_W'(1);
  assign w_bit_end  = (r_cnt == '0);

  always_comb begin
    w_stop_load = w_bit_load;
    case (r_stop)
      2'b01:   w_stop_load = {r_baud, 1'b1};                             // 2P - 1
      2'b10:   w_stop_load = w_period + (w_period >> 1) - CNT_W'(1);     // P + P/2 - 1
      default: w_stop_load = w_bit_load;                                 // P - 1
    endcase
  end

  // State register and all datapath/output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_baud    <= '0;
      r_stop    <= '0;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
      r_tx      <= 1'b1;
      r_ack     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_baud    <= w_baud_nxt;
      r_stop    <= w_stop_nxt;
      r_par_en  <= w_par_en_nxt;
      r_par_bit <= w_par_bit_nxt;
      r_tx      <= w_tx_nxt;
      r_ack     <= w_ack_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Next-state and next-output logic. Outputs are computed one cycle ahead
  // so that uart_tx changes on the same edge the state does.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_baud_nxt    = r_baud;
    w_stop_nxt    = r_stop;
    w_par_en_nxt  = r_par_en;
    w_par_bit_nxt = r_par_bit;
    w_tx_nxt      = r_tx;
    w_ack_nxt     = 1'b0;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;

    if ((r_state != S_IDLE) && !w_bit_end) begin
      w_cnt_nxt = r_cnt - CNT_W'(1);
    end

    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_state_nxt   = S_START;
          w_shift_nxt   = tx_data;
          w_baud_nxt    = baudrate;
          w_stop_nxt    = stop;
          w_par_en_nxt  = parity_en;
          // Parity is resolved from the captured character right away so
          // the odd/even selection does not need its own shadow register.
          w_par_bit_nxt = (^tx_data) ^ parity_odd;
          w_cnt_nxt     = {1'b0, baudrate};
          w_bit_idx_nxt = '0;
          w_tx_nxt      = 1'b0;
          w_ack_nxt     = 1'b1;
          w_busy_nxt    = 1'b1;
        end
      end

      S_START: begin
        if (w_bit_end) begin
          w_state_nxt   = S_DATA;
          w_cnt_nxt     = w_bit_load;
          w_bit_idx_nxt = '0;
          w_tx_nxt      = r_shift[0];
        end
      end

      S_DATA: begin
        if (w_bit_end) begin
          if (r_bit_idx == LAST_IDX) begin
            if (r_par_en) begin
              w_state_nxt = S_PARITY;
              w_cnt_nxt   = w_bit_load;
              w_tx_nxt    = r_par_bit;
            end else begin
              w_state_nxt = S_STOP;
              w_cnt_nxt   = w_stop_load;
              w_tx_nxt    = 1'b1;
            end
          end else begin
            // r_shift[0] is the bit on the line; the next one is r_shift[1].
            w_bit_idx_nxt = r_bit_idx + IDX_W'(1);
            w_shift_nxt   = r_shift >> 1;
            w_cnt_nxt     = w_bit_load;
            w_tx_nxt      = r_shift[1];
          end
        end
      end

      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = S_STOP;
          w_cnt_nxt   = w_stop_load;
          w_tx_nxt    = 1'b1;
        end
      end

      S_STOP: begin
        if (w_bit_end) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_tx_nxt    = 1'b1;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_tx_nxt    = 1'b1;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign uart_tx = r_tx;
  assign req_ack = r_ack;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - directed self-checking bench for uart_tx_ctrl

module tb_uart_tx_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic [8:0]  tb_data;
  logic [1:0]  tb_stop;
  logic        tb_pe;
  logic        tb_po;
  logic [15:0] tb_baud;
  logic        req8, req5, req9;
  logic        ack8, busy8, done8, tx8;
  logic        ack5, busy5, done5, tx5;
  logic        ack9, busy9, done9, tx9;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_done8 = 0;
  int n_ack8 = 0;
  int exp_done8 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (done8) n_done8 <= n_done8 + 1;
    if (ack8)  n_ack8  <= n_ack8 + 1;
  end

  uart_tx_ctrl #(.DATA_W(8), .BAUD_W(16)) dut8 (
    .clk(clk), .resetn(resetn), .tx_data(tb_data[7:0]), .stop(tb_stop),
    .parity_en(tb_pe), .parity_odd(tb_po), .baudrate(tb_baud), .req(req8),
    .req_ack(ack8), .busy(busy8), .done(done8), .uart_tx(tx8)
  );

  uart_tx_ctrl #(.DATA_W(5), .BAUD_W(16)) dut5 (
    .clk(clk), .resetn(resetn), .tx_data(tb_data[4:0]), .stop(tb_stop),
    .parity_en(tb_pe), .parity_odd(tb_po), .baudrate(tb_baud), .req(req5),
    .req_ack(ack5), .busy(busy5), .done(done5), .uart_tx(tx5)
  );

  uart_tx_ctrl #(.DATA_W(9), .BAUD_W(16)) dut9 (
    .clk(clk), .resetn(resetn), .tx_data(tb_data), .stop(tb_stop),
    .parity_en(tb_pe), .parity_odd(tb_po), .baudrate(tb_baud), .req(req9),
    .req_ack(ack9), .busy(busy9), .done(done9), .uart_tx(tx9)
  );

  function automatic logic get_tx(input int sel);
    case (sel)
      1:       return tx5;
      2:       return tx9;
      default: return tx8;
    endcase
  endfunction

  function automatic logic get_ack(input int sel);
    case (sel)
      1:       return ack5;
      2:       return ack9;
      default: return ack8;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      1:       return busy5;
      2:       return busy9;
      default: return busy8;
    endcase
  endfunction

  function automatic logic get_done(input int sel);
    case (sel)
      1:       return done5;
      2:       return done9;
      default: return done8;
    endcase
  endfunction

  task automatic set_req(input int sel, input logic v);
    case (sel)
      1:       req5 = v;
      2:       req9 = v;
      default: req8 = v;
    endcase
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one frame on the selected DUT and checks acceptance, the full
  // serial waveform cycle by cycle, and the done/busy timing. Must be
  // called at a falling edge. Inputs are scrambled halfway through the frame.
  task automatic run_frame(input int sel, input logic [8:0] d, input logic [1:0] st,
                           input logic pe, input logic po, input int baud,
                           input bit hold, input string tag,
                           output int ack_cyc, output int n_out);
    int   w, p, stopc, n, bad;
    logic par;
    logic exp_q[$];
    bit   got;
    w = (sel == 1) ? 5 : (sel == 2) ? 9 : 8;
    p = baud + 1;
    stopc = (st == 2'b01) ? 2 * p : (st == 2'b10) ? p + p / 2 : p;
    par = po;
    for (int b = 0; b < p; b++) exp_q.push_back(1'b0);
    for (int i = 0; i < w; i++) begin
      par ^= d[i];
      for (int b = 0; b < p; b++) exp_q.push_back(d[i]);
    end
    if (pe) for (int b = 0; b < p; b++) exp_q.push_back(par);
    for (int b = 0; b < stopc; b++) exp_q.push_back(1'b1);
    n = exp_q.size();
    n_out = n;
    ack_cyc = 0;

    tb_data = d;
    tb_stop = st;
    tb_pe   = pe;
    tb_po   = po;
    tb_baud = baud[15:0];
    set_req(sel, 1'b1);

    got = 1'b0;
    for (int t = 0; t < 300 && !got; t++) begin
      @(negedge clk);
      if (get_ack(sel)) got = 1'b1;
    end
    chk({tag, "_ack"}, 64'(got), 64'd1);
    if (!got) begin
      set_req(sel, 1'b0);
      return;
    end
    ack_cyc = cyc;
    chk({tag, "_busy"}, 64'(get_busy(sel)), 64'd1);
    if (!hold) set_req(sel, 1'b0);

    bad = 0;
    for (int c = 1; c <= n; c++) begin
      if (c > 1) begin
        @(negedge clk);
        if (get_ack(sel) || get_done(sel) || !get_busy(sel)) bad++;
      end
      if (get_tx(sel) !== exp_q[c-1]) bad++;
      if (c == n / 2) begin
        tb_data = ~d;
        tb_stop = ~st;
        tb_pe   = ~pe;
        tb_po   = ~po;
        tb_baud = baud[15:0] + 16'd5;
      end
    end
    chk({tag, "_wave"}, 64'(bad), 64'd0);

    @(negedge clk);
    chk({tag, "_done"}, {61'd0, get_done(sel), get_busy(sel), get_tx(sel)}, 64'b101);
    if (sel == 0) exp_done8++;
  endtask

  initial begin
    int a1, a2, a3, n1, n2, n3, acks_before, dones_before;

    resetn  = 1'b0;
    req8    = 1'b0;
    req5    = 1'b0;
    req9    = 1'b0;
    tb_data = '0;
    tb_stop = 2'b00;
    tb_pe   = 1'b0;
    tb_po   = 1'b0;
    tb_baud = 16'd3;

    #12;
    chk("rst_tx",   64'(tx8),   64'd1);
    chk("rst_ack",  64'(ack8),  64'd0);
    chk("rst_busy", 64'(busy8), 64'd0);
    chk("rst_done", 64'(done8), 64'd0);
    chk("rst_tx5_tx9", {62'd0, tx5, tx9}, 64'b11);

    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Basic 8N1 frame: 0x55 at P=4, done 40 cycles after req_ack
    run_frame(0, 9'h055, 2'b00, 1'b0, 1'b0, 3, 1'b0, "basic", a1, n1);
    chk("basic_len", 64'(n1), 64'd40);

    // Parity on 0x07: even -> 1, odd -> 0, 44-cycle frames
    run_frame(0, 9'h007, 2'b00, 1'b1, 1'b0, 3, 1'b0, "par_even", a1, n1);
    run_frame(0, 9'h007, 2'b00, 1'b1, 1'b1, 3, 1'b0, "par_odd", a1, n1);

    // Stop codes at P=4: 4/8/6/4 cycles of stop
    run_frame(0, 9'h0A3, 2'b00, 1'b0, 1'b0, 3, 1'b0, "stop00", a1, n1);
    run_frame(0, 9'h0A3, 2'b01, 1'b0, 1'b0, 3, 1'b0, "stop01", a1, n1);
    run_frame(0, 9'h0A3, 2'b10, 1'b1, 1'b0, 3, 1'b0, "stop10", a1, n1);
    run_frame(0, 9'h0A3, 2'b11, 1'b0, 1'b1, 3, 1'b0, "stop11", a1, n1);

    // Held request: three frames, each spaced N+1 from the previous ack
    acks_before = n_ack8;
    run_frame(0, 9'h011, 2'b00, 1'b0, 1'b0, 2, 1'b1, "hold1", a1, n1);
    run_frame(0, 9'h0E2, 2'b01, 1'b1, 1'b0, 2, 1'b1, "hold2", a2, n2);
    run_frame(0, 9'h033, 2'b10, 1'b1, 1'b1, 2, 1'b1, "hold3", a3, n3);
    req8 = 1'b0;
    chk("hold_gap12", 64'(a2 - a1), 64'(n1 + 1));
    chk("hold_gap23", 64'(a3 - a2), 64'(n2 + 1));
    repeat (20) @(negedge clk);
    chk("hold_ack_count", 64'(n_ack8 - acks_before), 64'd3);

    // Reset in the middle of the data bits
    dones_before = n_done8;
    tb_data = 9'h0F0;
    tb_stop = 2'b00;
    tb_pe   = 1'b0;
    tb_baud = 16'd3;
    req8    = 1'b1;
    @(negedge clk);
    req8 = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid_busy_before", 64'(busy8), 64'd1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_out", {61'd0, tx8, busy8, ack8}, 64'b100);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (50) @(negedge clk);
    chk("mid_no_done", 64'(n_done8 - dones_before), 64'd0);
    run_frame(0, 9'h03C, 2'b00, 1'b1, 1'b0, 3, 1'b0, "after_rst", a1, n1);

    // Minimum period P=1
    run_frame(0, 9'h096, 2'b00, 1'b0, 1'b0, 0, 1'b0, "p1_8n1", a1, n1);
    chk("p1_len", 64'(n1), 64'd10);
    run_frame(0, 9'h0C9, 2'b10, 1'b1, 1'b1, 0, 1'b0, "p1_stop15", a1, n1);
    run_frame(0, 9'h05A, 2'b01, 1'b0, 1'b0, 0, 1'b0, "p1_stop2", a1, n1);

    // Character widths 5 and 9
    run_frame(1, 9'h013, 2'b00, 1'b1, 1'b1, 1, 1'b0, "w5", a1, n1);
    run_frame(1, 9'h00A, 2'b10, 1'b0, 1'b0, 2, 1'b0, "w5_b", a1, n1);
    run_frame(2, 9'h1A5, 2'b01, 1'b0, 1'b0, 2, 1'b0, "w9", a1, n1);
    run_frame(2, 9'h14B, 2'b00, 1'b1, 1'b0, 1, 1'b0, "w9_par", a1, n1);

    repeat (5) @(negedge clk);
    chk("done_pulses", 64'(n_done8), 64'(exp_done8));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
